// File: rtl/booth_controller.sv
// Sequencing FSM for the 8-bit radix-2 Booth multiplier datapath.
// Loads M and Q, then runs eight add/subtract + arithmetic-shift steps.
module booth_controller (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic eqz,
  input  logic Q0,
  input  logic Q_1,
  output logic load_M,
  output logic load_Q,
  output logic clear_A,
  output logic clear_ff,
  output logic load_count,
  output logic load_A,
  output logic addsub,
  output logic shift_A,
  output logic shift_Q,
  output logic decr,
  output logic clear_Q,
  output logic busy,
  output logic done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_M = 3'd1,
    S_LOAD_Q = 3'd2,
    S_EVAL   = 3'd3,
    S_SHIFT  = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  state_e state_q, state_d;
  logic   busy_q, done_q;

  // Next state and datapath strobes; EVAL strobes follow the live Q0/Q_1 pair.
  always_comb begin
    state_d    = state_q;
    load_M     = 1'b0;
    load_Q     = 1'b0;
    clear_A    = 1'b0;
    clear_ff   = 1'b0;
    load_count = 1'b0;
    load_A     = 1'b0;
    addsub     = 1'b0;
    shift_A    = 1'b0;
    shift_Q    = 1'b0;
    decr       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD_M;
      end
      S_LOAD_M: begin
        load_M  = 1'b1;
        state_d = S_LOAD_Q;
      end
      S_LOAD_Q: begin
        load_Q     = 1'b1;
        clear_A    = 1'b1;
        clear_ff   = 1'b1;
        load_count = 1'b1;
        state_d    = S_EVAL;
      end
      S_EVAL: begin
        if (eqz) begin
          state_d = S_DONE;
        end else if (Q0 != Q_1) begin
          load_A  = 1'b1;
          addsub  = ~Q0;
          state_d = S_SHIFT;
        end else begin
          shift_A = 1'b1;
          shift_Q = 1'b1;
          decr    = 1'b1;
        end
      end
      S_SHIFT: begin
        shift_A = 1'b1;
        shift_Q = 1'b1;
        decr    = 1'b1;
        state_d = S_EVAL;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State plus status flags, registered against the upcoming state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign clear_Q = 1'b0;

endmodule

// File: doc/booth_controller.md
# booth_controller

Sequencing FSM for the 8-bit radix-2 Booth multiplier datapath (`booth_data_path`). On `start` it loads the multiplicand into M and the multiplier into Q from the shared `data_in` bus, clears A and Q_1, and loads the iteration counter. It then runs eight Booth steps, each an optional add/subtract followed by an arithmetic right shift of {A,Q}. When the counter reports zero it pulses `done`, with the 16-bit product {A,Q} valid at the datapath output.

## Interface
- No parameters. Operand width (8) and iteration count (8) are fixed by the datapath.
- `clk`  in  1  sole clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a multiply; sampled only in IDLE.
- `eqz`  in  1  datapath counter == 0.
- `Q0`  in  1  LSB of Q register.
- `Q_1`  in  1  Booth history bit.
- `load_M`, `load_Q`, `clear_A`, `clear_ff`, `load_count`  out  1 each  initialisation strobes.
- `load_A`  out  1  write ALU result into A.
- `addsub`  out  1  ALU select: 1 = A+M, 0 = A−M.
- `shift_A`, `shift_Q`  out  1 each  arithmetic right shift of {A,Q}; always asserted together.
- `decr`  out  1  decrement iteration counter.
- `clear_Q`  out  1  held 0; not used by this sequence.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse; product valid.

## Operation
- Reset value of every output is 0. The FSM enters IDLE asynchronously on `rst`.
- Any output not listed as active in a state is 0 in that state.
- States: IDLE, LOAD_M, LOAD_Q, EVAL, SHIFT, DONE.
- **IDLE**
  - `start`=1 → LOAD_M.
  - `eqz`, `Q0` and `Q_1` are ignored.
- **LOAD_M**
  - `load_M`=1; the multiplicand must be on `data_in` this cycle.
  - Next state: LOAD_Q.
- **LOAD_Q**
  - `load_Q`, `clear_A`, `clear_ff` and `load_count` = 1; the multiplier must be on `data_in` this cycle.
  - Next state: EVAL.
- **EVAL** (priority order)
  1. `eqz`=1 → DONE, no strobes.
  2. `Q0`≠`Q_1` → `load_A`=1, `addsub`=~`Q0` (01 → add, 10 → subtract); next state SHIFT.
  3. `Q0`==`Q_1` → `shift_A`, `shift_Q`, `decr` = 1; stay in EVAL.
- **SHIFT**
  - `shift_A`, `shift_Q`, `decr` = 1.
  - `Q0`/`Q_1` are not re-examined here: the datapath Q_1 flop reloads every cycle, so the decision made in EVAL is final.
  - Next state: EVAL.
- **DONE**
  - `done`=1 for exactly one cycle.
  - Next state: IDLE.
- `addsub` is meaningful only while `load_A`=1; it is 0 otherwise.
- `start` while `busy`=1 is ignored and is not queued. `start` held high through DONE begins a new operation from IDLE in the following cycle.
- Reset mid-operation aborts immediately and leaves the datapath registers unchanged. The next `start` fully re-initialises them.
- Operands are two's complement. The product is a signed 16-bit value.

## Timing
- `start` is sampled at edge e0, the transition into LOAD_M.
- Cycle numbering after e0: LOAD_M = 1, LOAD_Q = 2, Booth steps from cycle 3.
- Each Booth step takes 1 cycle (no arithmetic) or 2 cycles (arithmetic + shift).
- Let k = number of arithmetic steps.
  - Final EVAL (`eqz`=1) is cycle 11+k.
  - `done` is high in cycle 12+k.
  - `busy` is high in cycles 1 through 12+k.
- Latency range: 12 cycles (k=0) to 20 cycles (k=8).
- Exactly 8 `decr` pulses per operation. `shift_A`=`shift_Q`=`decr` in every cycle.
- Exactly one `load_M` pulse and one `load_Q` pulse per operation, in consecutive cycles.

## Test plan
- **Reset**: assert `rst` asynchronously mid-EVAL → all outputs 0 at once, no clock needed. Release, `start` → clean run with `done` at the nominal cycle.
- **Zero multiplier**: M=8'd5, Q=8'h00 → k=0. `done` in cycle 12, 8 shift cycles, `load_A` never asserted, product 16'h0000.
- **Alternating bits**: M=8'd3, Q=8'h55 → k=8. `load_A` alternates with `addsub` = 0,1,0,1,…; `done` in cycle 20; product 16'd255.
- **Negative operand**: M=8'd7, Q=8'hFF (−1) → k=1, a single subtract in the first step; `done` in cycle 13; product 16'hFFF9.
- **Start while busy**: pulse `start` in cycles 5 and 12 of a Q=8'h00 run → no effect; exactly one `done`; `busy` drops after cycle 12.
- **Back-to-back**: hold `start`=1 continuously → successive `done` pulses separated by one IDLE cycle; each product correct (5×3=15, then −2×−2=4).
